// File: rtl/df_pkg.sv
// Shared definitions for the serial odd-coefficient multiplier: FSM states and counter sizing.
package df_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a step counter that runs 0 .. n_steps-1.
  function automatic int cnt_width(input int n_steps);
    return (n_steps <= 2) ? 1 : $clog2(n_steps);
  endfunction

endpackage

// File: rtl/df_addshift.sv
// One shift-and-add step: conditionally accumulate the sample, then double it.
// Purely combinational; the caller registers both results.
module df_addshift #(
  parameter int AW = 11
) (
  input  logic [AW-1:0] i_acc,
  input  logic [AW-1:0] i_samp,
  input  logic          i_bit,
  output logic [AW-1:0] o_acc,
  output logic [AW-1:0] o_samp
);

  assign o_acc  = i_bit ? (i_acc + i_samp) : i_acc;
  assign o_samp = i_samp << 1;

endmodule

// File: rtl/df_seq_multiplier.sv
// Serial scaler: out = (data*(2*coef+1) + R) >> (COEF_W+1); valid COEF_W+1 cycles after accept.
// Single operand in flight; in_ready low while busy, result held in DONE until out_ready.
module df_seq_multiplier
  import df_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 2,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int AW = DATA_W + COEF_W + 1;
  localparam int MW = COEF_W + 1;
  localparam int CW = cnt_width(MW);
  localparam logic [AW-1:0] R_INIT = (ROUND != 0) ? (AW'(1) << COEF_W) : AW'(0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     r_samp;
  logic [MW-1:0]     r_mult;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_out;
  logic [AW-1:0]     w_acc_nxt;
  logic [AW-1:0]     w_samp_nxt;
  logic              w_last;

  df_addshift #(.AW(AW)) u_step (
    .i_acc  (r_acc),
    .i_samp (r_samp),
    .i_bit  (r_mult[0]),
    .o_acc  (w_acc_nxt),
    .o_samp (w_samp_nxt)
  );

  assign w_last = (r_state == RUN) && (r_cnt == CW'(COEF_W));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Multiplier bits are consumed from bit 0 by shifting r_mult right each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_samp <= '0;
      r_mult <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc  <= R_INIT;
            r_samp <= AW'(in_data);
            r_mult <= {in_coef, 1'b1};
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_acc  <= w_acc_nxt;
          r_samp <= w_samp_nxt;
          r_mult <= r_mult >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_out <= DATA_W'(w_acc_nxt >> (COEF_W + 1));
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out;

endmodule

// File: tb/tb_df_seq_multiplier.sv
// Bench for df_seq_multiplier: three configurations (trunc, round, wide coef) checked against
// a transaction-level model every cycle, plus directed literal expectations.
module tb_df_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic [3:0] in_coef   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_data  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  df_seq_multiplier #(.DATA_W(8), .COEF_W(2), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_coef(in_coef[0][1:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  df_seq_multiplier #(.DATA_W(8), .COEF_W(2), .ROUND(1)) u_round (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_coef(in_coef[1][1:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  df_seq_multiplier #(.DATA_W(8), .COEF_W(4), .ROUND(0)) u_wide (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_coef(in_coef[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  function automatic int cfg_cw(input int k);
    return (k == 2) ? 4 : 2;
  endfunction

  function automatic int cfg_round(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int model(input int d, input int c, input int cw, input int rnd);
    return (d * (2 * c + 1) + (rnd != 0 ? (1 << cw) : 0)) >> (cw + 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Transaction-level model: idle / busy for cw+1 edges / holding a result.
  bit m_init = 1'b0;
  bit m_busy  [3];
  bit m_valid [3];
  int m_cyc   [3];
  int m_pend  [3];
  int m_data  [3];

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      for (int k = 0; k < 3; k++) begin
        m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_data[k] = 0; m_cyc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!m_busy[k] && !m_valid[k]) begin
          if (in_valid[k]) begin
            m_busy[k] = 1'b1;
            m_cyc[k]  = 0;
            m_pend[k] = model(int'(in_data[k]), int'(in_coef[k]) & ((1 << cfg_cw(k)) - 1),
                              cfg_cw(k), cfg_round(k));
          end
        end else if (m_busy[k]) begin
          m_cyc[k]++;
          if (m_cyc[k] == cfg_cw(k) + 1) begin
            m_busy[k]  = 1'b0;
            m_valid[k] = 1'b1;
            m_data[k]  = m_pend[k];
          end
        end else if (out_ready[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dut%0d in_ready", k), int'(in_ready[k]), int'(!m_busy[k] && !m_valid[k]));
        chk($sformatf("dut%0d out_valid", k), int'(out_valid[k]), int'(m_valid[k]));
        chk($sformatf("dut%0d out_data", k), int'(out_data[k]), m_data[k]);
      end
    end
  end

  task automatic txn(input int k, input int d, input int c, input int exp_lit,
                     input int stall, input bit busy);
    int lat;
    @(negedge clk);
    chk($sformatf("dut%0d ready_before_offer", k), int'(in_ready[k]), 1);
    in_data[k]   = 8'(d);
    in_coef[k]   = 4'(c);
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      if (busy) begin
        in_valid[k] = ~in_valid[k];
        in_data[k]  = 8'(8'hA5 + lat);
        in_coef[k]  = 4'(lat + 1);
      end
      @(negedge clk);
      lat++;
    end
    in_valid[k] = 1'b0;
    chk($sformatf("dut%0d latency d=%0d c=%0d", k, d, c), lat, cfg_cw(k) + 1);
    chk($sformatf("dut%0d result d=%0d c=%0d", k, d, c), int'(out_data[k]), exp_lit);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk($sformatf("dut%0d stall%0d out_valid", k, i), int'(out_valid[k]), 1);
      chk($sformatf("dut%0d stall%0d out_data", k, i), int'(out_data[k]), exp_lit);
      chk($sformatf("dut%0d stall%0d in_ready", k, i), int'(in_ready[k]), 0);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk($sformatf("dut%0d release out_valid", k), int'(out_valid[k]), 0);
    chk($sformatf("dut%0d release in_ready", k), int'(in_ready[k]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_coef[k] = '0; out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", int'(out_valid[0]), 0);
    chk("reset in_ready", int'(in_ready[0]), 1);
    chk("reset out_data", int'(out_data[0]), 0);

    txn(0, 200, 3, 175, 0, 1'b0);
    txn(0, 200, 0,  25, 0, 1'b0);
    txn(0,  13, 1,   4, 0, 1'b0);
    txn(1,  13, 1,   5, 0, 1'b0);
    txn(1, 255, 3, 223, 0, 1'b0);
    txn(2, 255, 15, 247, 0, 1'b0);
    txn(0, 200, 3, 175, 6, 1'b0);
    txn(0, 200, 3, 175, 0, 1'b1);

    // Reset on the second RUN cycle, with an operand offered during the reset edge.
    @(negedge clk);
    in_data[0] = 8'd90; in_coef[0] = 4'd3; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'd7; in_coef[0] = 4'd1;
    @(negedge clk);
    rst = 1'b0; in_valid[0] = 1'b0;
    chk("midrun_reset out_valid", int'(out_valid[0]), 0);
    chk("midrun_reset out_data", int'(out_data[0]), 0);
    chk("midrun_reset in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    chk("midrun_reset not_accepted", int'(in_ready[0]), 1);

    txn(0, 100, 2, 62, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
